// File: rtl/action_select.sv
// Action selection for the Q-routing datapath. Scans this node's neighbour table for the
// highest-Q next hop, then applies an LFSR-driven epsilon-greedy choice.
module action_select #(
  parameter int                    WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] TBL_BASE   = 16'h0100,
  parameter int                    ADDR_STEP  = 2,
  parameter int                    MAX_NBR    = 8,
  parameter logic [7:0]            EPSILON    = 8'd26,
  parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  output logic [WORD_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [WORD_WIDTH-1:0] action,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] best_q,
  output logic                  no_route,
  output logic                  done_action,
  output logic [2:0]            state_dbg
);

  // start/done_action form a level handshake: a run begins when start=1 is sampled
  // with done_action=0; done_action then stays high (results stable) until start=0
  // is sampled, and start must be seen low for at least one cycle between runs.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CNT  = 3'd1,
    SCAN = 3'd2,
    EXPL = 3'd3,
    PICK = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0]            SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(ADDR_STEP);
  localparam logic [3:0]            NMAX = 4'(MAX_NBR);

  state_t                state, state_n;
  logic [3:0]            n, n_cap, cnt;
  logic [2:0]            k, idx;
  logic [7:0]            lfsr, lfsr_next, elig;
  logic                  found, exploring;
  logic                  cur_elig, last_q, found_any, take, k_ge_n, k_ok, explore;
  logic [WORD_WIDTH-1:0] id_buf [0:7];

  assign state_dbg = state;

  // Even read index is an ID, odd is its Q; idx is the table entry being read.
  assign n_cap     = (mem_data_out > WORD_WIDTH'(MAX_NBR)) ? NMAX : mem_data_out[3:0];
  assign idx       = cnt[3:1];
  assign cur_elig  = (id_buf[idx] != MY_NODE_ID);
  assign last_q    = (state == SCAN) && cnt[0] && (idx == 3'(n - 4'd1));
  assign found_any = found || (cnt[0] && cur_elig);
  assign take      = cnt[0] && cur_elig && (!found || (mem_data_out > best_q));
  assign k_ge_n    = ({1'b0, k} >= n);
  assign k_ok      = !k_ge_n && elig[k];
  assign explore   = (lfsr < EPSILON);
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start && !done_action) state_n = CNT;
      CNT:  state_n = (n_cap == 4'd0) ? DONE : SCAN;
      SCAN: begin
        if (last_q) begin
          if (!found_any)  state_n = DONE;
          else if (explore) state_n = EXPL;
          else             state_n = PICK;
        end
      end
      EXPL: if (k_ok) state_n = PICK;
      PICK: state_n = DONE;
      DONE: if (done_action && !start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      address     <= '0;
      action      <= '0;
      besthop     <= '0;
      best_q      <= '0;
      no_route    <= 1'b0;
      done_action <= 1'b0;
      lfsr        <= SEED;
      n           <= '0;
      cnt         <= '0;
      k           <= '0;
      elig        <= '0;
      found       <= 1'b0;
      exploring   <= 1'b0;
      for (int i = 0; i < 8; i++) id_buf[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start && !done_action) address <= TBL_BASE;
        CNT: begin
          n        <= n_cap;
          cnt      <= '0;
          found    <= 1'b0;
          no_route <= 1'b0;
          if (n_cap == 4'd0) begin
            action   <= '1;
            besthop  <= '1;
            best_q   <= '0;
            no_route <= 1'b1;
          end else begin
            address <= TBL_BASE + STEP;
          end
        end
        SCAN: begin
          cnt <= cnt + 4'd1;
          if (!last_q) address <= address + STEP;
          if (!cnt[0]) begin
            id_buf[idx] <= mem_data_out;
          end else begin
            elig[idx] <= cur_elig;
            if (take) begin
              besthop <= id_buf[idx];
              best_q  <= mem_data_out;
              found   <= 1'b1;
            end
          end
          if (last_q) begin
            k         <= lfsr[2:0];
            exploring <= explore;
            if (!found_any) begin
              no_route <= 1'b1;
              action   <= '1;
              besthop  <= '1;
              best_q   <= '0;
            end
          end
        end
        EXPL: begin
          // Fold k into range first, then walk forward past self entries.
          if (k_ge_n)                            k <= 3'({1'b0, k} - n);
          else if (!elig[k] && ({1'b0, k} + 4'd1 == n)) k <= 3'd0;
          else if (!elig[k])                     k <= k + 3'd1;
        end
        PICK: action <= exploring ? id_buf[k] : besthop;
        DONE: begin
          if (!done_action) begin
            done_action <= 1'b1;
            lfsr        <= lfsr_next;
          end else if (!start) begin
            done_action <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_action_select.sv
// Directed bench for action_select: three instances (greedy, always-explore, EPSILON=128)
// share one table memory and one start/reset so each run exercises all three policies.
module tb_action_select;

  logic        clock = 1'b0;
  logic        nreset, start;
  logic [15:0] my_id;
  logic [15:0] mem [0:65535];

  logic [15:0] a_grd, d_grd, act_grd, bh_grd, bq_grd;
  logic [15:0] a_exp, d_exp, act_exp, bh_exp, bq_exp;
  logic [15:0] a_b2b, d_b2b, act_b2b, bh_b2b, bq_b2b;
  logic        nr_grd, dn_grd, nr_exp, dn_exp, nr_b2b, dn_b2b;
  logic [2:0]  st_grd, st_exp, st_b2b;

  int n_pass = 0;
  int n_chk  = 0;
  int lat;

  logic        mon_en = 1'b0;
  int          chg_cnt;
  logic [15:0] prev_a, max_a;

  assign d_grd = mem[a_grd];
  assign d_exp = mem[a_exp];
  assign d_b2b = mem[a_b2b];

  always #5 clock = ~clock;

  action_select #(.EPSILON(8'd0)) u_grd (
    .clock(clock), .nreset(nreset), .start(start), .MY_NODE_ID(my_id),
    .address(a_grd), .mem_data_out(d_grd), .action(act_grd), .besthop(bh_grd),
    .best_q(bq_grd), .no_route(nr_grd), .done_action(dn_grd), .state_dbg(st_grd));

  action_select #(.EPSILON(8'd255), .LFSR_SEED(8'h05)) u_exp (
    .clock(clock), .nreset(nreset), .start(start), .MY_NODE_ID(my_id),
    .address(a_exp), .mem_data_out(d_exp), .action(act_exp), .besthop(bh_exp),
    .best_q(bq_exp), .no_route(nr_exp), .done_action(dn_exp), .state_dbg(st_exp));

  action_select #(.EPSILON(8'd128), .LFSR_SEED(8'hA5)) u_b2b (
    .clock(clock), .nreset(nreset), .start(start), .MY_NODE_ID(my_id),
    .address(a_b2b), .mem_data_out(d_b2b), .action(act_b2b), .besthop(bh_b2b),
    .best_q(bq_b2b), .no_route(nr_b2b), .done_action(dn_b2b), .state_dbg(st_b2b));

  // Address-change monitor on the greedy instance.
  always @(negedge clock) begin
    if (mon_en) begin
      if (a_grd !== prev_a && a_grd != 16'h0100) chg_cnt <= chg_cnt + 1;
      if (a_grd > max_a) max_a <= a_grd;
      prev_a <= a_grd;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    step(2);
    nreset = 1'b1;
    step(1);
  endtask

  task automatic clear_tbl();
    for (int i = 16'h0100; i < 16'h0180; i++) mem[i] = 16'h0000;
  endtask

  task automatic put_entry(input int i, input logic [15:0] id, input logic [15:0] q);
    mem[16'h0102 + 16'(4 * i)] = id;
    mem[16'h0104 + 16'(4 * i)] = q;
  endtask

  // Raise start, measure greedy-instance latency, keep start high for `hold` cycles total.
  task automatic run(input int hold, output int l);
    start = 1'b1;
    l = 0;
    while (dn_grd !== 1'b1 && l < 60) begin
      step(1);
      l++;
    end
    if (l < hold) step(hold - l);
  endtask

  task automatic stop_run();
    start = 1'b0;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nreset = 1'b0;
    start  = 1'b0;
    my_id  = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    step(2);
    check("rst_state", {13'd0, st_grd}, 16'd0);
    check("rst_address", a_grd, 16'h0000);
    check("rst_action", act_grd, 16'h0000);
    check("rst_done", {15'd0, dn_exp}, 16'd0);
    nreset = 1'b1;
    step(1);

    // Greedy with a tie on Q=40: lower index (ID6) wins.
    clear_tbl();
    mem[16'h0100] = 16'd3;
    put_entry(0, 16'd5, 16'd10);
    put_entry(1, 16'd6, 16'd40);
    put_entry(2, 16'd7, 16'd40);
    run(20, lat);
    check("grd_latency", 16'(lat), 16'd10);
    check("grd_done_held", {15'd0, dn_grd}, 16'd1);
    check("grd_besthop", bh_grd, 16'd6);
    check("grd_best_q", bq_grd, 16'd40);
    check("grd_action", act_grd, 16'd6);
    check("grd_no_route", {15'd0, nr_grd}, 16'd0);
    check("exp_action_k5", act_exp, 16'd7);
    check("b2b_seed_greedy", act_b2b, 16'd6);
    stop_run();
    check("grd_done_fall", {15'd0, dn_grd}, 16'd0);

    // Self entry at index 0 is skipped even though its Q is highest.
    clear_tbl();
    my_id = 16'd2;
    mem[16'h0100] = 16'd2;
    put_entry(0, 16'd2, 16'd90);
    put_entry(1, 16'd4, 16'd15);
    run(40, lat);
    check("self_besthop", bh_grd, 16'd4);
    check("self_best_q", bq_grd, 16'd15);
    check("self_action", act_grd, 16'd4);
    check("b2b_wrap_skip_self", act_b2b, 16'd4);
    stop_run();

    // Empty table.
    clear_tbl();
    my_id = 16'd0;
    mem[16'h0100] = 16'd0;
    run(10, lat);
    check("empty_latency", 16'(lat), 16'd3);
    check("empty_action", act_grd, 16'hFFFF);
    check("empty_besthop", bh_grd, 16'hFFFF);
    check("empty_best_q", bq_grd, 16'd0);
    check("empty_no_route", {15'd0, nr_grd}, 16'd1);
    stop_run();

    // Count above capacity is clamped to 8; entry 8 must never be read.
    clear_tbl();
    mem[16'h0100] = 16'd20;
    put_entry(0, 16'd10, 16'd3);
    put_entry(1, 16'd11, 16'd9);
    put_entry(2, 16'd12, 16'd4);
    put_entry(3, 16'd13, 16'd9);
    put_entry(4, 16'd14, 16'd1);
    put_entry(5, 16'd15, 16'd2);
    put_entry(6, 16'd16, 16'd8);
    put_entry(7, 16'd17, 16'd0);
    put_entry(8, 16'd99, 16'd500);
    chg_cnt = 0;
    max_a   = a_grd;
    prev_a  = a_grd;
    mon_en  = 1'b1;
    run(40, lat);
    mon_en  = 1'b0;
    check("clamp_latency", 16'(lat), 16'd20);
    check("clamp_reads", 16'(chg_cnt), 16'd16);
    check("clamp_max_addr", max_a, 16'h0120);
    check("clamp_addr_hold", a_grd, 16'h0120);
    check("clamp_besthop", bh_grd, 16'd11);
    check("clamp_best_q", bq_grd, 16'd9);
    check("clamp_no_route", {15'd0, nr_grd}, 16'd0);
    stop_run();

    // Explore from a fresh seed: k = 5 folds to 2.
    do_reset();
    clear_tbl();
    mem[16'h0100] = 16'd3;
    put_entry(0, 16'd5, 16'd10);
    put_entry(1, 16'd6, 16'd40);
    put_entry(2, 16'd7, 16'd1);
    run(40, lat);
    check("expl_action", act_exp, 16'd7);
    check("expl_besthop", bh_exp, 16'd6);
    check("expl_best_q", bq_exp, 16'd40);
    check("expl_grd_action", act_grd, 16'd6);
    check("expl_b2b_action", act_b2b, 16'd6);
    stop_run();

    // Reset in the middle of SCAN clears outputs asynchronously.
    start = 1'b1;
    lat = 0;
    while (st_grd !== 3'd2 && lat < 20) begin
      step(1);
      lat++;
    end
    check("scan_reached", {13'd0, st_grd}, 16'd2);
    step(4);
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_state", {13'd0, st_grd}, 16'd0);
    check("mid_rst_address", a_grd, 16'h0000);
    check("mid_rst_action", act_grd, 16'h0000);
    check("mid_rst_besthop", bh_grd, 16'h0000);
    check("mid_rst_best_q", bq_grd, 16'h0000);
    check("mid_rst_flags", {14'd0, nr_grd, dn_grd}, 16'd0);
    start = 1'b0;
    step(1);
    nreset = 1'b1;
    step(1);
    run(40, lat);
    check("post_rst_latency", 16'(lat), 16'd10);
    check("post_rst_besthop", bh_grd, 16'd6);
    check("post_rst_action", act_grd, 16'd6);
    check("post_rst_b2b_seed", act_b2b, 16'd6);
    stop_run();

    // Back-to-back runs with a one-cycle start-low gap.
    do_reset();
    run(40, lat);
    check("b2b_run1_action", act_b2b, 16'd6);
    start = 1'b0;
    step(1);
    check("b2b_gap_done", {15'd0, dn_b2b}, 16'd0);
    run(40, lat);
    check("b2b_run2_latency", 16'(lat), 16'd10);
    check("b2b_run2_action", act_b2b, 16'd7);
    check("b2b_run2_besthop", bh_b2b, 16'd6);
    check("b2b_run2_grd", act_grd, 16'd6);
    stop_run();
    check("b2b_final_done", {15'd0, dn_b2b}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
